// File: rtl/exp_ctrl_pkg.sv
// Shared types and widths for the exception/interrupt controller.
package exp_ctrl_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned INT_FLAG_BIT = DATA_W - 1;
  localparam int unsigned IDX_W        = 4;

  typedef enum logic [4:0] {
    EXP_INST_MISALIGN  = 5'd0,
    EXP_INST_FAULT     = 5'd1,
    EXP_ILLEGAL        = 5'd2,
    EXP_BREAK          = 5'd3,
    EXP_LOAD_MISALIGN  = 5'd4,
    EXP_LOAD_FAULT     = 5'd5,
    EXP_STORE_MISALIGN = 5'd6,
    EXP_STORE_FAULT    = 5'd7,
    EXP_ECALL          = 5'd8
  } exp_code_t;

  typedef enum logic [1:0] {
    TVEC_DIRECT = 2'b00,
    TVEC_VECTOR = 2'b01
  } tvec_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/exp_ctrl_if.sv
// Commit-side event bundle and fetch redirect handshake.
interface exp_ctrl_if
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR = ADDR_W,
  parameter int unsigned DATA = DATA_W
);

  logic            commit_valid;
  logic            commit_exp_;
  exp_code_t       commit_exp_code;
  logic            commit_eret_;
  logic [ADDR-1:0] commit_pc;
  logic [ADDR-1:0] commit_npc;
  logic [DATA-1:0] commit_tval;

  logic            redirect_valid;
  logic [ADDR-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output commit_valid, commit_exp_, commit_exp_code, commit_eret_,
           commit_pc, commit_npc, commit_tval, redirect_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_exp_, commit_exp_code, commit_eret_,
           commit_pc, commit_npc, commit_tval, redirect_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/exp_vec_calc.sv
// Handler PC generator: direct base, or base + 4*code for vectored interrupts.
module exp_vec_calc
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR = ADDR_W,
  parameter int unsigned DATA = DATA_W
) (
  input  logic [DATA-1:0] tvec,
  input  logic [DATA-2:0] cause_code,
  input  logic            is_int,
  output logic [ADDR-1:0] handler_pc_c
);

  logic [ADDR-1:0] base;
  logic [ADDR-1:0] offset;

  always_comb begin
    base         = {tvec[ADDR-1:2], 2'b00};
    offset       = ADDR'(cause_code) << 2;
    handler_pc_c = base;
    if (is_int && (tvec[1:0] == TVEC_VECTOR)) begin
      handler_pc_c = base + offset;
    end
  end

endmodule

// File: rtl/exp_ctrl.sv
// Trap/eret controller: latches trap state, flushes the pipeline and
// redirects fetch through a valid/ready handshake.
module exp_ctrl
  import exp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR     = ADDR_W,
  parameter int unsigned DATA     = DATA_W,
  parameter int unsigned NUM_INT  = 4,
  parameter int unsigned INT_BASE = 16
) (
  input  logic               clk,
  input  logic               reset,
  exp_ctrl_if.slave          bus,
  input  logic [NUM_INT-1:0] irq,
  input  logic [NUM_INT-1:0] int_en,
  input  logic [DATA-1:0]    creg_tvec,
  input  logic               ie_we,
  input  logic               ie_wdata,
  output logic               exp_busy,
  output logic               flush,
  output logic [ADDR-1:0]    epc,
  output logic [DATA-1:0]    cause,
  output logic [DATA-1:0]    tval,
  output logic               ie,
  output logic               pie
);

  state_t          state, state_d;
  logic            busy_d, flush_d, rv_d, ie_d, pie_d;
  logic [ADDR-1:0] epc_d, rpc_d;
  logic [DATA-1:0] cause_d, tval_d;
  logic            redirect_valid;
  logic [ADDR-1:0] redirect_pc;

  logic [NUM_INT-1:0] pend;
  logic [IDX_W-1:0]   int_idx;
  logic [DATA-2:0]    int_code;
  logic               int_sel;
  logic [ADDR-1:0]    handler_pc_c;

  // Lowest pending index has priority.
  always_comb begin
    pend    = irq & int_en;
    int_idx = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend[i]) int_idx = IDX_W'(i);
    end
    int_code = (DATA-1)'(INT_BASE) + (DATA-1)'(int_idx);
    int_sel  = bus.commit_exp_ && bus.commit_eret_ && ie && (|pend);
  end

  exp_vec_calc #(.ADDR(ADDR), .DATA(DATA)) u_vec_calc (
    .tvec         (creg_tvec),
    .cause_code   (int_code),
    .is_int       (int_sel),
    .handler_pc_c (handler_pc_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    epc_d   = epc;
    cause_d = cause;
    tval_d  = tval;
    rpc_d   = redirect_pc;
    ie_d    = ie;
    pie_d   = pie;

    if (ie_we) ie_d = ie_wdata;

    unique case (state)
      ST_IDLE: begin
        if (bus.commit_valid) begin
          if (!bus.commit_exp_) begin
            state_d = ST_FLUSH;
            epc_d   = bus.commit_pc;
            cause_d = {1'b0, (DATA-1)'(bus.commit_exp_code)};
            tval_d  = bus.commit_tval;
            rpc_d   = handler_pc_c;
            pie_d   = ie;
            ie_d    = 1'b0;
          end else if (!bus.commit_eret_) begin
            state_d = ST_FLUSH;
            rpc_d   = epc;
            ie_d    = pie;
            pie_d   = 1'b1;
          end else if (int_sel) begin
            state_d = ST_FLUSH;
            epc_d   = bus.commit_npc;
            cause_d = {1'b1, int_code};
            tval_d  = '0;
            rpc_d   = handler_pc_c;
            pie_d   = ie;
            ie_d    = 1'b0;
          end
        end
      end
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (bus.redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    flush_d = (state_d == ST_FLUSH);
    rv_d    = (state_d == ST_REDIRECT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      exp_busy       <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      epc            <= '0;
      cause          <= '0;
      tval           <= '0;
      ie             <= 1'b0;
      pie            <= 1'b0;
    end else begin
      state          <= state_d;
      exp_busy       <= busy_d;
      flush          <= flush_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
      epc            <= epc_d;
      cause          <= cause_d;
      tval           <= tval_d;
      ie             <= ie_d;
      pie            <= pie_d;
    end
  end

  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_exp_ctrl.sv
// Directed bench for exp_ctrl with hand-computed expectations.
module tb_exp_ctrl;
  import exp_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq, int_en;
  logic [31:0] creg_tvec;
  logic        ie_we, ie_wdata;
  logic        exp_busy, flush, ie, pie;
  logic [31:0] epc, cause, tval;

  int n_cmp = 0;
  int n_mis = 0;

  exp_ctrl_if #(.ADDR(32), .DATA(32)) bus ();

  exp_ctrl #(.ADDR(32), .DATA(32), .NUM_INT(4), .INT_BASE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .irq       (irq),
    .int_en    (int_en),
    .creg_tvec (creg_tvec),
    .ie_we     (ie_we),
    .ie_wdata  (ie_wdata),
    .exp_busy  (exp_busy),
    .flush     (flush),
    .epc       (epc),
    .cause     (cause),
    .tval      (tval),
    .ie        (ie),
    .pie       (pie)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_commit();
    bus.commit_valid    = 1'b0;
    bus.commit_exp_     = 1'b1;
    bus.commit_eret_    = 1'b1;
    bus.commit_exp_code = EXP_INST_MISALIGN;
    bus.commit_pc       = '0;
    bus.commit_npc      = '0;
    bus.commit_tval     = '0;
  endtask

  task automatic raise_exp(input exp_code_t code, input logic [31:0] pc, input logic [31:0] tv);
    bus.commit_valid    = 1'b1;
    bus.commit_exp_     = 1'b0;
    bus.commit_exp_code = code;
    bus.commit_pc       = pc;
    bus.commit_npc      = pc + 32'd4;
    bus.commit_tval     = tv;
  endtask

  initial begin
    reset = 1'b1;
    irq = '0; int_en = '0; creg_tvec = '0; ie_we = 1'b0; ie_wdata = 1'b0;
    bus.redirect_ready = 1'b0;
    idle_commit();
    #12;
    check("rst_busy", 64'(exp_busy), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_rv", 64'(bus.redirect_valid), 64'h0);
    check("rst_rpc", 64'(bus.redirect_pc), 64'h0);
    check("rst_epc_cause", {epc, cause}, 64'h0);
    check("rst_ie_pie", {62'h0, ie, pie}, 64'h0);
    step();
    reset = 1'b0;
    step();

    // Direct-mode exception.
    creg_tvec = 32'h0002_BFF8;
    raise_exp(EXP_BREAK, 32'h1000, 32'h55);
    step();
    idle_commit();
    check("dir_flush", {62'h0, flush, exp_busy}, 64'h3);
    check("dir_rv_n1", 64'(bus.redirect_valid), 64'h0);
    check("dir_epc", 64'(epc), 64'h1000);
    check("dir_cause", 64'(cause), 64'h3);
    check("dir_tval", 64'(tval), 64'h55);
    check("dir_ie", {62'h0, ie, pie}, 64'h0);
    step();
    check("dir_rv_n2", {62'h0, bus.redirect_valid, flush}, 64'h2);
    check("dir_rpc", 64'(bus.redirect_pc), 64'h0002_BFF8);
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    check("dir_done", {62'h0, bus.redirect_valid, exp_busy}, 64'h0);

    // Enable interrupts, then vectored interrupt with a competing ie write.
    ie_we = 1'b1; ie_wdata = 1'b1;
    step();
    ie_we = 1'b0;
    check("ie_write", 64'(ie), 64'h1);
    creg_tvec = 32'h0002_BFF9;
    int_en = 4'b1111;
    irq = 4'b1010;
    bus.commit_valid = 1'b1;
    bus.commit_pc  = 32'h2000;
    bus.commit_npc = 32'h2004;
    bus.commit_tval = 32'hABCD;
    ie_we = 1'b1; ie_wdata = 1'b1;
    step();
    ie_we = 1'b0;
    idle_commit();
    irq = '0;
    check("vec_flush", 64'(flush), 64'h1);
    check("vec_cause", 64'(cause), 64'h8000_0011);
    check("vec_epc", 64'(epc), 64'h2004);
    check("vec_tval", 64'(tval), 64'h0);
    check("vec_ie_pie", {62'h0, ie, pie}, 64'h1);
    step();
    check("vec_rpc", 64'(bus.redirect_pc), 64'h0002_C03C);
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    check("vec_done", 64'(exp_busy), 64'h0);

    // eret returns to the saved epc and restores ie.
    bus.commit_valid = 1'b1;
    bus.commit_eret_ = 1'b0;
    step();
    idle_commit();
    check("eret_ie_pie", {62'h0, ie, pie}, 64'h3);
    check("eret_epc", 64'(epc), 64'h2004);
    check("eret_cause", 64'(cause), 64'h8000_0011);
    step();
    check("eret_rpc", {31'h0, bus.redirect_valid, bus.redirect_pc}, 64'h1_0000_2004);
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;

    // Exception + eret + interrupt together in vectored mode; ready stalled.
    irq = 4'b0100;
    raise_exp(EXP_ILLEGAL, 32'h3000, 32'hDEAD);
    bus.commit_eret_ = 1'b0;
    step();
    check("pri_cause", 64'(cause), 64'h2);
    check("pri_epc", 64'(epc), 64'h3000);
    check("pri_tval", 64'(tval), 64'hDEAD);
    check("pri_ie_pie", {62'h0, ie, pie}, 64'h1);
    bus.commit_pc = 32'h3100;
    step();
    for (int k = 0; k < 3; k++) begin
      check("hold_rv", {31'h0, bus.redirect_valid, bus.redirect_pc}, 64'h1_0002_BFF8);
      check("hold_busy", 64'(exp_busy), 64'h1);
      step();
    end
    check("hold_epc", 64'(epc), 64'h3000);
    idle_commit();
    irq = '0;
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    check("pri_done", {62'h0, bus.redirect_valid, exp_busy}, 64'h0);

    // Reset while in REDIRECT aborts everything.
    raise_exp(EXP_ECALL, 32'h4000, 32'h0);
    step();
    idle_commit();
    step();
    check("pre_rst_rv", 64'(bus.redirect_valid), 64'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_out", {60'h0, exp_busy, flush, bus.redirect_valid, ie}, 64'h0);
    check("mid_rst_regs", {epc, cause}, 64'h0);
    check("mid_rst_rpc", {bus.redirect_pc, tval}, 64'h0);
    step();
    reset = 1'b0;

    // Pending interrupt with ie=0 is not taken, then taken once ie=1.
    irq = 4'b0001;
    bus.commit_valid = 1'b1;
    bus.commit_npc = 32'h5004;
    step();
    step();
    check("noie_busy", {62'h0, exp_busy, flush}, 64'h0);
    bus.commit_valid = 1'b0;
    ie_we = 1'b1; ie_wdata = 1'b1;
    step();
    ie_we = 1'b0;
    bus.commit_valid = 1'b1;
    step();
    idle_commit();
    check("late_int_cause", 64'(cause), 64'h8000_0010);
    check("late_int_epc", 64'(epc), 64'h5004);
    step();
    check("late_int_rpc", 64'(bus.redirect_pc), 64'h0002_C038);
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    check("late_int_done", 64'(exp_busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
